// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operation request in, HI/LO state and completion out.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdata;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, rdata, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, rdata, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves RUN once remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_DIVU  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MULT  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MFHI  = 3'b110;
  localparam logic [2:0] OP_MFLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;        // product accumulator, or {remainder, quotient}
  logic [W2-1:0]    mcand_q, mcand_d;    // shifted multiplicand, or divisor in the low half
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             op_signed;
  logic             op_is_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last_step;

  // Operand magnitudes; only signed ops take absolute values.
  always_comb begin
    op_signed = (bus.op == OP_DIV) || (bus.op == OP_MULT);
    op_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    a_mag     = (op_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag     = (op_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // Restoring-divide step and sign fix-up datapath.
  always_comb begin
    rem_sh   = acc_q[W2-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    last_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: begin
              hi_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              done_d = 1'b1;
            end
            OP_MFHI: begin
              rdata_d = hi_q;
              done_d  = 1'b1;
            end
            OP_MFLO: begin
              rdata_d = lo_q;
              done_d  = 1'b1;
            end
            default: begin
              if (op_is_div && (bus.b == '0)) begin
                // Divide by zero bypasses the iteration entirely.
                hi_d   = bus.a;
                lo_d   = '1;
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                state_d   = S_RUN;
                busy_d    = 1'b1;
                cnt_d     = CW'(WIDTH);
                is_div_d  = op_is_div;
                neg_res_d = op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d = op_signed && bus.a[WIDTH-1];
                if (op_is_div) begin
                  acc_d    = {{WIDTH{1'b0}}, a_mag};
                  mcand_d  = {{WIDTH{1'b0}}, b_mag};
                  mplier_d = '0;
                end else begin
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a_mag};
                  mplier_d = b_mag;
                end
              end
            end
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (!rem_diff[WIDTH]) begin
            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[W2-2:0], 1'b0};
          end
          last_step = (cnt_q == CW'(1));
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = {mcand_q[W2-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
          last_step = (cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
          last_step = (cnt_q == CW'(1));
`endif
        end
        if (last_step) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.rdata       = rdata_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits, encoded 000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO.
REQ-006 The block SHALL have port a, input, WIDTH bits: rs operand, the dividend or multiplicand, and the MTHI/MTLO source.
REQ-007 The block SHALL have port b, input, WIDTH bits: rt operand, the divisor or multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an iterative operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have ports hi and lo, outputs, WIDTH bits each: architectural HI/LO registers.
REQ-011 The block SHALL have port rdata, output, WIDTH bits: MFHI/MFLO result, valid in the done cycle.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: pulse coincident with done for a DIV/DIVU with b==0.

Function
REQ-013 The state machine SHALL have the states IDLE, RUN and FIX; start is accepted only in IDLE and is ignored in RUN and FIX.
REQ-014 MTHI/MTLO SHALL write a into hi/lo at the accepting edge, with done high the following cycle; the block stays in IDLE.
REQ-015 MFHI/MFLO SHALL register hi/lo into rdata at the accepting edge, with done high the following cycle; hi and lo are unchanged.
REQ-016 MULT/MULTU/DIV/DIVU SHALL enter RUN at the accepting edge, loading |a|, |b| and counter = WIDTH; magnitudes apply only to signed ops.
REQ-017 RUN SHALL process one bit per cycle: shift-add for multiply, restoring subtract for divide; the counter decrements, and RUN moves to FIX when the counter reaches 0.
REQ-018 FIX SHALL apply the sign correction: signed product negated when a[MSB]^b[MSB]; quotient sign a^b; remainder sign follows a.
REQ-019 At the edge leaving FIX the block SHALL write hi/lo (product high/low, or remainder/quotient), return to IDLE, and pulse done.
REQ-020 Without early-out, done SHALL occur in cycle WIDTH+2, with the start-acceptance cycle counted as cycle 0; busy is high in cycles 1..WIDTH+1.
REQ-021 hi and lo SHALL NOT change during RUN or FIX; intermediate results are held in internal registers only.
REQ-022 DIV/DIVU with b==0 SHALL skip RUN: hi=a, lo=all ones, and done and div_by_zero are high in cycle 1.
REQ-023 DIV of the most-negative value by -1 SHALL give lo=most-negative and hi=0, with no flag.
REQ-024 rdata SHALL hold its last value except on MFHI/MFLO.

Reset
REQ-025 Reset SHALL force IDLE and drive busy=0, done=0, div_by_zero=0, hi=0, lo=0 and rdata=0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse, and hi/lo SHALL read 0 afterwards.
REQ-027 When reset and start are asserted together, reset SHALL win and start is dropped.

Configuration
REQ-028 Macro MULDIV_EARLY_OUT_EN, when defined, SHALL let multiply leave RUN for FIX once the remaining multiplier bits are all zero; latency = max(1,k)+2, where k is the bit length of |b|.
REQ-029 Without MULDIV_EARLY_OUT_EN, every multiply SHALL take the fixed WIDTH+2 latency; divide latency is unaffected by the macro.

Verification
REQ-030 A bench SHALL check, at WIDTH=32: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in cycle 34.
REQ-031 A bench SHALL check: MULT a=0xFFFFFFFD b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 A bench SHALL check two divides: DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF, div_by_zero and done in cycle 1.
REQ-033 A bench SHALL check: MTHI a=0x00001234, then MFHI -> rdata=0x00001234; and a start with op=MTLO during a busy MULTU leaves lo equal to the product.
REQ-034 A bench SHALL check: reset in cycle 10 of a MULTU -> busy=0, hi=lo=0, no done pulse.
REQ-035 A bench SHALL check: MULTU a=9 b=5 -> lo=45, with done in cycle 5 when MULDIV_EARLY_OUT_EN is defined and in cycle 34 when it is not.
